// File: rtl/axis_frame_sink.sv
// AXI4-Stream RGB frame sink: checks Nrows x Ncol geometry and reports per-channel
// pixel sums with a one-cycle done strobe for each complete frame.
module axis_frame_sink #(
    parameter int Nrows = 480,
    parameter int Ncol  = 640,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    input  logic [23:0]      s_axis_tdata,
    output logic             s_axis_tready,
    input  logic             err_clear,
    output logic             frame_done,
    output logic [SUM_W-1:0] sum_r,
    output logic [SUM_W-1:0] sum_g,
    output logic [SUM_W-1:0] sum_b,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      drop_cnt,
    output logic             err_early_eol,
    output logic             err_late_eol,
    output logic             err_sof_mid
);
    localparam int COL_W = $clog2(Ncol + 1);
    localparam int ROW_W = $clog2(Nrows + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(Ncol - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(Nrows - 1);

    typedef enum logic [1:0] {WAIT_SOF, IN_FRAME, REPORT} state_t;

    state_t            state_reg, state_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [15:0]       drop_reg, drop_next;
    logic [15:0]       frame_cnt_reg;
    logic              tready_reg, done_reg;
    logic              early_reg, late_reg, sof_reg;
    logic              early_set, late_set, sof_set;
    logic              sum_load, sum_add, accept, start;

    // Channel index 0 = B, 1 = G, 2 = R, matching the tdata byte order.
    logic [SUM_W-1:0]  chan_ext [3];
    logic [SUM_W-1:0]  run_sum_reg [3];
    logic [SUM_W-1:0]  run_sum_next [3];
    logic [SUM_W-1:0]  sum_out_reg [3];

    assign accept = s_axis_tvalid && tready_reg;
    assign start  = accept && s_axis_tuser && (state_reg != REPORT);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan_ext[gi]     = SUM_W'(s_axis_tdata[8*gi +: 8]);
            assign run_sum_next[gi] = sum_load ? chan_ext[gi] :
                                      sum_add  ? run_sum_reg[gi] + chan_ext[gi] :
                                                 run_sum_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        drop_next  = drop_reg;
        sum_load   = 1'b0;
        sum_add    = 1'b0;
        early_set  = 1'b0;
        late_set   = 1'b0;
        sof_set    = 1'b0;
        case (state_reg)
            WAIT_SOF: begin
                if (accept && !s_axis_tuser && drop_reg != 16'hFFFF)
                    drop_next = drop_reg + 16'd1;
            end
            IN_FRAME: begin
                if (accept && s_axis_tuser) begin
                    sof_set = 1'b1;
                end else if (accept) begin
                    sum_add = 1'b1;
                    // A line ends on tlast or at the last column, whichever comes first.
                    if (s_axis_tlast || col_reg == COL_LAST) begin
                        early_set = s_axis_tlast && (col_reg != COL_LAST);
                        late_set  = !s_axis_tlast && (col_reg == COL_LAST);
                        col_next  = '0;
                        row_next  = row_reg + 1'b1;
                        if (row_reg == ROW_LAST)
                            state_next = REPORT;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            REPORT:   state_next = WAIT_SOF;
            default:  state_next = WAIT_SOF;
        endcase
        // SOF restarts the frame from either WAIT_SOF or mid-frame.
        if (start) begin
            sum_load   = 1'b1;
            state_next = IN_FRAME;
            if (s_axis_tlast && Ncol == 1) begin
                col_next = '0;
                row_next = ROW_W'(1);
            end else begin
                col_next = COL_W'(1);
                row_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= WAIT_SOF;
            col_reg       <= '0;
            row_reg       <= '0;
            drop_reg      <= '0;
            frame_cnt_reg <= '0;
            tready_reg    <= 1'b0;
            done_reg      <= 1'b0;
            early_reg     <= 1'b0;
            late_reg      <= 1'b0;
            sof_reg       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                run_sum_reg[i] <= '0;
                sum_out_reg[i] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            drop_reg   <= drop_next;
            tready_reg <= (state_next != REPORT);
            done_reg   <= (state_next == REPORT);
            // A new error in the same cycle as err_clear keeps its flag set.
            early_reg  <= (early_reg && !err_clear) || early_set;
            late_reg   <= (late_reg  && !err_clear) || late_set;
            sof_reg    <= (sof_reg   && !err_clear) || sof_set;
            for (int i = 0; i < 3; i++)
                run_sum_reg[i] <= run_sum_next[i];
            if (state_next == REPORT) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                for (int i = 0; i < 3; i++)
                    sum_out_reg[i] <= run_sum_next[i];
            end
        end
    end

    assign s_axis_tready = tready_reg;
    assign frame_done    = done_reg;
    assign sum_b         = sum_out_reg[0];
    assign sum_g         = sum_out_reg[1];
    assign sum_r         = sum_out_reg[2];
    assign frame_cnt     = frame_cnt_reg;
    assign drop_cnt      = drop_reg;
    assign err_early_eol = early_reg;
    assign err_late_eol  = late_reg;
    assign err_sof_mid   = sof_reg;
endmodule

// File: tb/tb_axis_frame_sink.sv
// Directed bench for axis_frame_sink with a 4x8 frame: table of frame scenarios
// plus hand-written clear-vs-error and mid-frame reset sequences.
module tb_axis_frame_sink;
    localparam int NR = 4;
    localparam int NC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tready;
    logic        err_clear = 1'b0;
    logic        frame_done;
    logic [31:0] sum_r, sum_g, sum_b;
    logic [15:0] frame_cnt, drop_cnt;
    logic        err_early_eol, err_late_eol, err_sof_mid;

    axis_frame_sink #(.Nrows(NR), .Ncol(NC), .SUM_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .s_axis_tready(s_axis_tready), .err_clear(err_clear),
        .frame_done(frame_done), .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
        .err_early_eol(err_early_eol), .err_late_eol(err_late_eol),
        .err_sof_mid(err_sof_mid)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int trdy_low_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (frame_done) done_cnt = done_cnt + 1;
            if (!s_axis_tready) trdy_low_cnt = trdy_low_cnt + 1;
        end
    end

    typedef struct {
        int          junk;
        logic [23:0] px;
        int          er, ec, lr;
        int          partial;
        bit          gaps;
        logic [31:0] esr, esg, esb;
        logic [15:0] efc, edc;
        logic [2:0]  efl;   // {early, late, sof}
    } scen_t;

    scen_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic beat(input logic u, input logic l, input logic [23:0] d);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = d;
        while (!s_axis_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) begin
            n_total++;
            $display("FAIL beat_timeout: tready=%0b, required 1 within 20 cycles", s_axis_tready);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] px, input int er, input int ec, input int lr,
                              input int maxb, input bit gaps, input bit clr_early);
        int n = 0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                logic u, l;
                if (n == maxb) return;
                u = (r == 0 && c == 0);
                if (r == er && c == ec) l = 1'b1;
                else if (r == lr)       l = 1'b0;
                else                    l = (c == NC - 1);
                err_clear = clr_early && r == er && c == ec;
                beat(u, l, px);
                err_clear = 1'b0;
                n++;
                if (gaps && c == 4) @(negedge clk);
                if (r == er && c == ec) break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {29'd0, s_axis_tready, frame_done, 1'b0}, 32'd0);
        chk({tag, "_sum_r"}, sum_r, 32'd0);
        chk({tag, "_sum_g"}, sum_g, 32'd0);
        chk({tag, "_sum_b"}, sum_b, 32'd0);
        chk({tag, "_cnts"}, {frame_cnt, drop_cnt}, 32'd0);
        chk({tag, "_flags"}, {29'd0, err_early_eol, err_late_eol, err_sof_mid}, 32'd0);
    endtask

    int d0, t0;

    initial begin
        //              junk px         er  ec  lr  part gaps  sr   sg    sb    fc  dc  flags
        tbl[0] = '{0, 24'h102030, -1, -1, -1,  0, 1'b0, 512, 1024, 1536, 1, 0, 3'b000};
        tbl[1] = '{0, 24'h102030, -1, -1, -1,  0, 1'b1, 512, 1024, 1536, 2, 0, 3'b000};
        tbl[2] = '{5, 24'h010203, -1, -1, -1,  0, 1'b0,  32,   64,   96, 3, 5, 3'b000};
        tbl[3] = '{0, 24'h0A0B0C,  1,  5,  2,  0, 1'b0, 300,  330,  360, 4, 5, 3'b110};
        tbl[4] = '{0, 24'h050607, -1, -1, -1, 19, 1'b0, 160,  192,  224, 5, 5, 3'b001};

        #3 rst = 1'b0;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("tready_after_reset", {31'd0, s_axis_tready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
            d0 = done_cnt;
            t0 = trdy_low_cnt;
            repeat (tbl[i].junk) beat(1'b0, 1'b0, 24'h55AA33);
            if (tbl[i].partial > 0)
                send_frame(24'hFFFFFF, -1, -1, -1, tbl[i].partial, 1'b0, 1'b0);
            send_frame(tbl[i].px, tbl[i].er, tbl[i].ec, tbl[i].lr, 1000, tbl[i].gaps, 1'b0);
            idle(3);
            $display("scenario %0d: done=%0d sums=%0d/%0d/%0d frame_cnt=%0d drop_cnt=%0d flags=%b%b%b",
                     i, done_cnt - d0, sum_r, sum_g, sum_b, frame_cnt, drop_cnt,
                     err_early_eol, err_late_eol, err_sof_mid);
            chk($sformatf("s%0d_done_pulses", i), done_cnt - d0, 1);
            chk($sformatf("s%0d_tready_low", i), trdy_low_cnt - t0, 1);
            chk($sformatf("s%0d_sum_r", i), sum_r, tbl[i].esr);
            chk($sformatf("s%0d_sum_g", i), sum_g, tbl[i].esg);
            chk($sformatf("s%0d_sum_b", i), sum_b, tbl[i].esb);
            chk($sformatf("s%0d_frame_cnt", i), frame_cnt, tbl[i].efc);
            chk($sformatf("s%0d_drop_cnt", i), drop_cnt, tbl[i].edc);
            chk($sformatf("s%0d_flags", i), {29'd0, err_early_eol, err_late_eol, err_sof_mid},
                {29'd0, tbl[i].efl});
        end

        // err_clear coincides with the early tlast: early survives, older sof flag is wiped.
        d0 = done_cnt;
        send_frame(24'hFFFFFF, -1, -1, -1, 10, 1'b0, 1'b0);
        send_frame(24'h0A0B0C, 1, 5, 2, 1000, 1'b0, 1'b1);
        idle(3);
        $display("clear_vs_error: flags=%b%b%b frame_cnt=%0d sum_r=%0d",
                 err_early_eol, err_late_eol, err_sof_mid, frame_cnt, sum_r);
        chk("cve_early", {31'd0, err_early_eol}, 32'd1);
        chk("cve_late", {31'd0, err_late_eol}, 32'd1);
        chk("cve_sof_cleared", {31'd0, err_sof_mid}, 32'd0);
        chk("cve_frame_cnt", frame_cnt, 32'd6);
        chk("cve_sum_r", sum_r, 32'd300);
        chk("cve_done_pulses", done_cnt - d0, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        $display("clear_idle: flags=%b%b%b", err_early_eol, err_late_eol, err_sof_mid);
        chk("clear_idle_flags", {29'd0, err_early_eol, err_late_eol, err_sof_mid}, 32'd0);

        // Reset in the middle of row 2, then a clean frame.
        send_frame(24'h102030, -1, -1, -1, 20, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        send_frame(24'h102030, -1, -1, -1, 1000, 1'b0, 1'b0);
        idle(3);
        $display("after_reset: done=%0d sums=%0d/%0d/%0d frame_cnt=%0d drop_cnt=%0d",
                 done_cnt - d0, sum_r, sum_g, sum_b, frame_cnt, drop_cnt);
        chk("rst_done_pulses", done_cnt - d0, 1);
        chk("rst_frame_cnt", frame_cnt, 32'd1);
        chk("rst_sum_r", sum_r, 32'd512);
        chk("rst_sum_g", sum_g, 32'd1024);
        chk("rst_sum_b", sum_b, 32'd1536);
        chk("rst_drop_cnt", drop_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axis_frame_sink.md
# axis_frame_sink

Receiving end of the AXI4-Stream video link driven by `frame_generator` and `gray_world`. The block accepts 24-bit RGB pixels framed by tuser (start of frame, SOF) and tlast (end of line, EOL), and checks the frame geometry against `Nrows`×`Ncol`. It accumulates per-channel pixel sums over each complete frame and reports them with a one-cycle done strobe. It gives benches and on-chip monitors a synthesizable alternative to file capture for the gray-world output path.

## Interface
- `Nrows`, 480: active lines per frame.
- `Ncol`, 640: pixels per line.
- `SUM_W`, 32: width of each channel sum. It must be ≥ 8 + ceil(log2(`Nrows`·`Ncol`)).
- `clk`  in  1  sole clock; every register is clocked on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_axis_tvalid`  in  1  pixel beat valid.
- `s_axis_tuser`  in  1  SOF, high on the first pixel of a frame.
- `s_axis_tlast`  in  1  EOL, high on the last pixel of a line.
- `s_axis_tdata`  in  24  pixel: [23:16] R, [15:8] G, [7:0] B.
- `s_axis_tready`  out  1  sink ready.
- `err_clear`  in  1  synchronous pulse that clears the sticky error flags.
- `frame_done`  out  1  one-cycle strobe when a complete frame has been received.
- `sum_r`, `sum_g`, `sum_b`  out  `SUM_W`  channel sums of the last complete frame.
- `frame_cnt`  out  16  number of complete frames received; wraps at 65535→0.
- `drop_cnt`  out  16  number of beats discarded while waiting for SOF; saturates at 65535.
- `err_early_eol`  out  1  sticky: tlast arrived with column < `Ncol`-1.
- `err_late_eol`  out  1  sticky: tlast was missing at column `Ncol`-1.
- `err_sof_mid`  out  1  sticky: tuser arrived inside a frame.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready`. No other input is sampled unless a beat is accepted; `err_clear` is the only exception.
- The state machine has three states: WAIT_SOF, IN_FRAME and REPORT.
- **WAIT_SOF**
  - A beat with tuser=1 starts a frame: col←1, row←0 (or col←0, row←1 if tlast=1 and `Ncol`=1), sums←pixel, state→IN_FRAME.
  - A beat with tuser=0 is discarded and increments `drop_cnt`.
- **IN_FRAME, normal beat:** add the channels to the running sums and advance the column.
- **Line end:** a line ends when tlast=1 or when col=`Ncol`-1, whichever comes first. At line end: col←0, row←row+1.
  - If tlast=1 and col<`Ncol`-1, set `err_early_eol`.
  - If col=`Ncol`-1 and tlast=0, set `err_late_eol` and force the line end.
- **Frame end:** a line end on row `Nrows`-1 completes the frame and sends the state to REPORT.
- **tuser=1 inside IN_FRAME:** set `err_sof_mid`, discard the partial frame and restart on this beat exactly as from WAIT_SOF. No report is made for the discarded frame.
- **REPORT** lasts one cycle, then the state returns to WAIT_SOF. In that cycle:
  - `frame_done` = 1.
  - The output sum registers load the running sums.
  - `frame_cnt` increments.
- **Arithmetic:** running sums are `SUM_W` bits; each 8-bit channel is zero-extended before the add. No saturation is required because the parameter rule guarantees no overflow.
- **`err_clear` vs. a new error:** `err_clear` clears all three sticky flags. If a new error occurs in the same cycle as `err_clear`, the new error wins and its flag ends up set.
- **Reset:** asserting `rst` low at any time, including mid-frame, immediately clears all state. The partial frame is lost and no `frame_done` is generated.

## Timing
- **Reset values:**
  - `s_axis_tready`=0.
  - `frame_done`=0.
  - `sum_r`/`sum_g`/`sum_b`=0.
  - `frame_cnt`=0 and `drop_cnt`=0.
  - All error flags=0.
  - State=WAIT_SOF.
- **`s_axis_tready`** is driven from a register.
  - It goes to 1 on the first rising edge after `rst` deasserts.
  - It is 0 for the single cycle the state machine is in REPORT and 1 otherwise.
- **Done latency:** `frame_done` is high in the cycle after the clock edge that accepts the final beat.
  - Sums and `frame_cnt` update on that same edge. All three are valid while `frame_done`=1 and hold until the next REPORT.
- **Error flags** are set on the edge that accepts the offending beat.
- **Throughput:** one beat per clock within a frame. Between frames the block loses exactly one beat slot (REPORT), so the minimum inter-frame gap the source must tolerate is 1 cycle with tready=0.
- **tvalid gaps** (tvalid=0 cycles) anywhere are legal and change no state.

## Test plan
- **Clean frames.** Set `Nrows`=4, `Ncol`=8 and send 2 clean frames with constant pixel 0x102030 and correct tuser/tlast.
  - Each frame gives `frame_done` for exactly 1 cycle with `sum_r`=512, `sum_g`=1024, `sum_b`=1536.
  - `frame_cnt`=2 and all error flags stay 0.
- **Leading junk and tready.** Send 5 beats with tuser=0 before the first SOF, then a clean frame.
  - `drop_cnt`=5 and the frame reports correctly.
  - tready is 0 for only the REPORT cycle.
- **Early and late EOL.** In a clean frame, assert tlast at col 5 on row 1 and omit tlast on row 2.
  - `err_early_eol`=1 and `err_late_eol`=1.
  - The frame still completes after 4 line ends; the sums cover 30 pixels.
- **SOF mid-frame.** Assert tuser at row 2, col 3, then send a full frame from that beat.
  - `err_sof_mid`=1 and only one `frame_done` occurs.
  - The sums cover exactly 32 pixels from the restarting beat.
- **Reset mid-frame.** Pull `rst` low during row 2, release it, then send a clean frame.
  - All outputs read 0 during reset.
  - After release, `frame_cnt`=1 with correct sums.
- **Clear vs. new error.** Pulse `err_clear` in the same cycle as an early tlast: `err_early_eol` stays 1. A later `err_clear` with no error in that cycle clears all three flags.
